// File: rtl/snn_step_scheduler.sv
// Run sequencer for the SNN neuron block array.
// Walks TS time steps, dispatching blocks 0..T-1 one at a time per step.
module snn_step_scheduler #(
  parameter int N  = 2,
  parameter int T  = 2,
  parameter int TA = ($clog2(T) > 0) ? $clog2(T) : 1,
  parameter int TS = 5,
  parameter int SW = ($clog2(TS) > 0) ? $clog2(TS) : 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          start,
  input  logic          abort,
  output logic          cfg_load,
  output logic          blk_go,
  output logic [TA-1:0] blk_sel,
  output logic [SW-1:0] step_idx,
  input  logic [T-1:0]  blk_done,
  output logic          step_tick,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          err_unexp
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_DISPATCH,
    S_WAIT,
    S_FIN
  } state_t;

  localparam logic [TA-1:0] LAST_BLK  = TA'(T - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(TS - 1);
  // A block array with no neurons has nothing to run.
  localparam bit            N_OK      = (N > 0);

  state_t       state;
  logic [T-1:0] sel_mask;
  logic         hit;
  logic         stray;
  logic         take_start;

  always_comb begin
    sel_mask   = T'(1) << blk_sel;
    hit        = |(blk_done & sel_mask);
    stray      = 1'b0;
    take_start = (state == S_IDLE) && start && N_OK;
    if (state == S_WAIT) begin
      stray = |(blk_done & ~sel_mask);
    end else begin
      stray = |blk_done;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      blk_sel   <= '0;
      step_idx  <= '0;
      cfg_load  <= 1'b0;
      blk_go    <= 1'b0;
      step_tick <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      err_unexp <= 1'b0;
    end else begin
      cfg_load  <= 1'b0;
      blk_go    <= 1'b0;
      step_tick <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      if (take_start) begin
        err_unexp <= 1'b0;
      end
      if (stray) begin
        err_unexp <= 1'b1;
      end
      if (abort && (state != S_IDLE)) begin
        state    <= S_IDLE;
        blk_sel  <= '0;
        step_idx <= '0;
        busy     <= 1'b0;
        aborted  <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (take_start) begin
              state    <= S_CFG;
              cfg_load <= 1'b1;
              busy     <= 1'b1;
              blk_sel  <= '0;
              step_idx <= '0;
            end
          end
          S_CFG: begin
            state  <= S_DISPATCH;
            blk_go <= 1'b1;
          end
          S_DISPATCH: begin
            state <= S_WAIT;
          end
          S_WAIT: begin
            if (hit) begin
              if (blk_sel != LAST_BLK) begin
                blk_sel <= blk_sel + TA'(1);
                state   <= S_DISPATCH;
                blk_go  <= 1'b1;
              end else if (step_idx != LAST_STEP) begin
                step_idx  <= step_idx + SW'(1);
                blk_sel   <= '0;
                step_tick <= 1'b1;
                state     <= S_DISPATCH;
                blk_go    <= 1'b1;
              end else begin
                state <= S_FIN;
                done  <= 1'b1;
              end
            end
          end
          S_FIN: begin
            state    <= S_IDLE;
            busy     <= 1'b0;
            blk_sel  <= '0;
            step_idx <= '0;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed bench for snn_step_scheduler with a delayed-done block model.
// Covers timing trace, full runs, abort, stray done, held start, reset.
module tb_snn_step_scheduler;
  localparam int T  = 2;
  localparam int TS = 5;
  localparam int TA = 1;
  localparam int SW = 3;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cfg_load;
  logic          blk_go;
  logic [TA-1:0] blk_sel;
  logic [SW-1:0] step_idx;
  logic [T-1:0]  blk_done = '0;
  logic          step_tick;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          err_unexp;

  int total = 0;
  int bad = 0;

  always #5 aclk = ~aclk;

  snn_step_scheduler #(
    .N (2),
    .T (T),
    .TS(TS)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .start    (start),
    .abort    (abort),
    .cfg_load (cfg_load),
    .blk_go   (blk_go),
    .blk_sel  (blk_sel),
    .step_idx (step_idx),
    .blk_done (blk_done),
    .step_tick(step_tick),
    .busy     (busy),
    .done     (done),
    .aborted  (aborted),
    .err_unexp(err_unexp)
  );

  // block model: done pulse lat cycles after blk_go, plus injected bits
  int            lat = 3;
  bit            pend = 0;
  int            cnt = 0;
  logic [TA-1:0] psel = '0;
  logic [T-1:0]  inj = '0;
  bit            go_s;
  bit            kill;
  logic [TA-1:0] sel_s;

  always @(posedge aclk) begin
    go_s  = blk_go;
    sel_s = blk_sel;
    kill  = !aresetn || abort;
    #2;
    blk_done = inj;
    if (kill || !aresetn) begin
      pend = 0;
    end else begin
      if (go_s) begin
        pend = 1;
        cnt  = lat;
        psel = sel_s;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          blk_done[psel] = 1'b1;
          pend = 0;
        end
      end
    end
  end

  int go_cnt = 0;
  int cfg_cnt = 0;
  int tick_cnt = 0;
  int done_cnt = 0;
  int abt_cnt = 0;
  logic [SW+TA-1:0] seq[$];

  always @(negedge aclk) begin
    if (blk_go) begin
      go_cnt++;
      seq.push_back({step_idx, blk_sel});
    end
    if (cfg_load) cfg_cnt++;
    if (step_tick) tick_cnt++;
    if (done) done_cnt++;
    if (aborted) abt_cnt++;
  end

  task automatic clr();
    go_cnt = 0;
    cfg_cnt = 0;
    tick_cnt = 0;
    done_cnt = 0;
    abt_cnt = 0;
    seq.delete();
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s: got no done in %0d cycles, want done", name, n);
    end
  endtask

  task automatic wait_wait(input int st, input int sl, input int budget,
                           input string name);
    int n;
    n = 0;
    while (!(busy && !blk_go && !cfg_load && !done &&
             step_idx == SW'(st) && blk_sel == TA'(sl)) && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s: got timeout, want WAIT at step %0d blk %0d",
               name, st, sl);
    end
  endtask

  typedef struct {
    logic       start;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[24];

  // {cfg_load, blk_go, blk_sel, step_idx, step_tick, busy, done} after edge e
  function automatic logic [8:0] exp_row(int e);
    logic c, g, tk, b, d;
    logic [TA-1:0] s;
    logic [SW-1:0] st;
    int i;
    c = 0; g = 0; tk = 0; b = 0; d = 0; s = '0; st = '0;
    if (e == 1) begin
      c = 1;
      b = 1;
    end else if (e >= 2 && e <= 21) begin
      i  = (e - 2) / 2;
      g  = ((e - 2) % 2 == 0);
      s  = TA'(i % 2);
      st = SW'(i / 2);
      tk = g && (i > 0) && (i % 2 == 0);
      b  = 1;
    end else if (e == 22) begin
      d  = 1;
      b  = 1;
      s  = TA'(1);
      st = SW'(4);
    end
    return {c, g, s, st, tk, b, d};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] act;
    for (int r = 0; r < 24; r++) begin
      tbl[r].start = (r == 0);
      tbl[r].exp   = exp_row(r + 1);
    end

    aresetn = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_cfg", cfg_load, 0);
    chk("rst_go", blk_go, 0);
    chk("rst_sel", blk_sel, 0);
    chk("rst_step", step_idx, 0);
    chk("rst_err", err_unexp, 0);
    aresetn = 1'b1;
    tick();

    // cycle-exact trace with 1-cycle blocks
    lat = 1;
    for (int r = 0; r < 24; r++) begin
      start = tbl[r].start;
      tick();
      act = {cfg_load, blk_go, blk_sel, step_idx, step_tick, busy, done};
      total++;
      if (act !== tbl[r].exp) begin
        bad++;
        $display("FAIL trace_row%0d: got=%b want=%b", r, act, tbl[r].exp);
      end
    end
    start = 1'b0;

    // full run, 3-cycle blocks
    lat = 3;
    clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300, "run1_done");
    tick();
    chk("run1_cfg", cfg_cnt, 1);
    chk("run1_go", go_cnt, 10);
    chk("run1_tick", tick_cnt, 4);
    chk("run1_donecnt", done_cnt, 1);
    chk("run1_busy", busy, 0);
    for (int i = 0; i < 10; i++) begin
      if (i < seq.size())
        chk($sformatf("run1_seq%0d", i), seq[i], {SW'(i / 2), TA'(i % 2)});
      else
        chk($sformatf("run1_seq%0d", i), 32'hdead, {SW'(i / 2), TA'(i % 2)});
    end

    // abort in WAIT at step 2 blk 1
    clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_wait(2, 1, 300, "abt_reach");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abt_pulse", aborted, 1);
    chk("abt_busy", busy, 0);
    chk("abt_step", step_idx, 0);
    chk("abt_sel", blk_sel, 0);
    tick();
    chk("abt_once", aborted, 0);
    repeat (6) tick();
    chk("abt_nodone", done_cnt, 0);
    chk("abt_cnt", abt_cnt, 1);
    chk("abt_idle", busy, 0);
    clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(300, "abt_rerun_done");
    tick();
    chk("abt_rerun_go", go_cnt, 10);
    chk("abt_rerun_done_cnt", done_cnt, 1);

    // stray done from blk 0 while awaiting blk 1
    clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_wait(1, 1, 300, "err_reach");
    chk("err_pre", err_unexp, 0);
    inj = 2'b01;
    tick();
    inj = '0;
    chk("err_set", err_unexp, 1);
    wait_done(300, "err_run_done");
    tick();
    chk("err_run_go", go_cnt, 10);
    chk("err_sticky", err_unexp, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("err_clr", err_unexp, 0);
    chk("err_clr_cfg", cfg_load, 1);
    wait_done(300, "err_run2_done");
    tick();

    // start held high through a run
    clr();
    start = 1'b1;
    wait_done(300, "hold_done1");
    chk("hold_cfg1", cfg_cnt, 1);
    tick();
    chk("hold_gap_cfg", cfg_load, 0);
    chk("hold_gap_busy", busy, 0);
    tick();
    chk("hold_recfg", cfg_load, 1);
    start = 1'b0;
    wait_done(300, "hold_done2");
    tick();
    chk("hold_cfg2", cfg_cnt, 2);
    chk("hold_go", go_cnt, 20);
    chk("hold_donecnt", done_cnt, 2);

    // reset in WAIT at step 3
    clr();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_wait(3, 0, 300, "rst_reach");
    aresetn = 1'b0;
    #1;
    act = {cfg_load, blk_go, blk_sel, step_idx, step_tick, busy, done};
    chk("mid_rst_outs", act, 0);
    chk("mid_rst_flags", {aborted, err_unexp}, 0);
    tick();
    tick();
    aresetn = 1'b1;
    clr();
    repeat (10) tick();
    chk("post_rst_go", go_cnt, 0);
    chk("post_rst_cfg", cfg_cnt, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_events", done_cnt + abt_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
